rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

Keystream generator and decryptor for the RC4 datapath. It runs after the S-box has been initialised and key-scheduled in the 256x8 S RAM. It walks the RC4 PRGA over the S RAM and reads ciphertext bytes from the encrypted_msg ROM. It XORs each keystream byte with the ciphertext and writes the plaintext into the decrypted_msg RAM, then signals completion to the top-level controller.

## Interface
Parameters:
- MSG_LEN, 32, number of message bytes processed (ROM depth)
- MSG_ADDR_WIDTH, 5, ROM and decrypted_msg address width
- S_ADDR_WIDTH, 8, S RAM address width (fixed, 256 entries)
- DATA_WIDTH, 8, byte width for all memories

Ports:
- clock  in  1  single system clock; all memories share it
- reset  in  1  asynchronous, active-high
- start  in  1  request to run; sampled only in IDLE/DONE
- done  out  1  high while in DONE
- s_address  out  S_ADDR_WIDTH  S RAM address
- s_data  out  DATA_WIDTH  S RAM write data
- s_wren  out  1  S RAM write enable
- s_q  in  DATA_WIDTH  S RAM registered read data
- rom_address  out  MSG_ADDR_WIDTH  encrypted_msg address
- rom_q  in  DATA_WIDTH  encrypted_msg registered read data
- dmsg_address  out  MSG_ADDR_WIDTH  decrypted_msg address
- dmsg_data  out  DATA_WIDTH  plaintext byte
- dmsg_wren  out  1  decrypted_msg write enable

## Operation
Memory model for all attached memories:
- Address is sampled at posedge.
- q is valid the cycle after.
- Writes land at posedge.
- Read-after-write next cycle returns the new value.

Internal registers: i, j (8-bit), k (MSG_ADDR_WIDTH+1 bits), si, sj, f, enc (8-bit).

All index arithmetic is mod 256 by natural 8-bit truncation (i+1, j+si, si+sj).

FSM states and transitions:
- IDLE: start=1 -> i<=1, j<=0, k<=0, go to RD_I.
- RD_I: s_address=i -> WAIT_I.
- WAIT_I: si<=s_q, j<=j+s_q -> RD_J.
- RD_J: s_address=j -> WAIT_J.
- WAIT_J: sj<=s_q -> WR_I.
- WR_I: s_address=i, s_data=sj, s_wren=1 -> WR_J.
- WR_J: s_address=j, s_data=si, s_wren=1 -> RD_F.
- RD_F: s_address=si+sj, rom_address=k -> WAIT_F.
- WAIT_F: f<=s_q, enc<=rom_q -> WR_OUT.
- WR_OUT: dmsg_address=k, dmsg_data=f^enc, dmsg_wren=1; i<=i+1, k<=k+1. If k==MSG_LEN-1 go to DONE, else go to RD_I.
- DONE: done=1. start=1 restarts exactly as from IDLE; otherwise stay.

Boundary behaviour:
- i==j: both swap writes hit the same location; the final value is si (equal to sj), which is correct RC4.
- i wraps 255->0 naturally.
- start is ignored in every busy state; no queuing.
- Reset mid-operation: state goes to IDLE and all outputs go to 0 immediately. The S RAM is left partially permuted, so the controller must re-run the key schedule before restarting.
- Write enables are never asserted outside WR_I, WR_J and WR_OUT.

## Timing
- Reset values: done=0, all addresses=0, all data=0, all wren=0, state=IDLE, i=j=k=0.
- Outputs are decoded combinationally from state and registers, so they are glitch-free at posedge sampling.
- 9 cycles per byte.
- With start sampled at edge 0: RD_I occupies cycle 1 and the first dmsg_wren occurs in cycle 9.
- done rises in cycle 9*MSG_LEN+1, which is cycle 289 for MSG_LEN=32.
- done stays high until start is sampled in DONE; it drops on the next cycle.

## Structure
- Shared package rc4_pkg holds:
  - the state enum (IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, RD_F, WAIT_F, WR_OUT, DONE);
  - the DATA_WIDTH and S_DEPTH=256 constants;
  - the MSG_LEN default.
- The key-schedule block reuses the same package.
- No sub-module: a single FSM plus datapath registers; the swap/XOR logic is too small to split.

## Test plan
- S preloaded identity, ROM all 0, MSG_LEN=32 -> dmsg[0]=2, dmsg[1]=5, dmsg[2]=7. Afterwards S[1]=1, S[2]=3, S[3]=5, S[5]=2.
- S identity, ROM[0]=45 -> dmsg[0]=47, written in cycle 9 after start. done rises in cycle 289 and stays high.
- Full run against a software RC4 model using key 00_00_03 after the key schedule, with the 32-byte ciphertext -> all 32 dmsg bytes match; s_wren pulses exactly 64 times and dmsg_wren exactly 32 times.
- start held high throughout the run -> no restart while busy. Restart occurs only after DONE, with done dropping one cycle later.
- reset asserted in cycle 50 with no clock edge -> outputs 0 immediately. After release, FSM is in IDLE, no writes until start.
- Restart from DONE with a re-initialised identity S -> the identical plaintext sequence is reproduced.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, memory geometry and the
// default message length used by the key-schedule and PRGA blocks.
package rc4_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int S_DEPTH         = 256;
  localparam int MSG_LEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_I   = 4'd1,
    ST_WAIT_I = 4'd2,
    ST_RD_J   = 4'd3,
    ST_WAIT_J = 4'd4,
    ST_WR_I   = 4'd5,
    ST_WR_J   = 4'd6,
    ST_RD_F   = 4'd7,
    ST_WAIT_F = 4'd8,
    ST_WR_OUT = 4'd9,
    ST_DONE   = 4'd10
  } rc4_state_e;

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA walker: generates one keystream byte per 9 cycles from the S RAM,
// XORs it with the matching ciphertext byte and stores the plaintext.
module rc4_prga_decrypt #(
  parameter int MSG_LEN        = 32,
  parameter int MSG_ADDR_WIDTH = 5,
  parameter int S_ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  output logic [S_ADDR_WIDTH-1:0]   s_address,
  output logic [DATA_WIDTH-1:0]     s_data,
  output logic                      s_wren,
  input  logic [DATA_WIDTH-1:0]     s_q,
  output logic [MSG_ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]     rom_q,
  output logic [MSG_ADDR_WIDTH-1:0] dmsg_address,
  output logic [DATA_WIDTH-1:0]     dmsg_data,
  output logic                      dmsg_wren
);
  import rc4_pkg::*;

  localparam int K_WIDTH = MSG_ADDR_WIDTH + 1;
  localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(MSG_LEN - 1);

  rc4_state_e r_state;
  rc4_state_e w_state_next;

  logic [S_ADDR_WIDTH-1:0] r_i;
  logic [S_ADDR_WIDTH-1:0] r_j;
  logic [K_WIDTH-1:0]      r_k;
  logic [DATA_WIDTH-1:0]   r_si;
  logic [DATA_WIDTH-1:0]   r_sj;
  logic [DATA_WIDTH-1:0]   r_f;
  logic [DATA_WIDTH-1:0]   r_enc;

  // start is honoured only when the walker is parked (IDLE or DONE)
  logic w_launch;
  assign w_launch = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode: fixed 9-state loop per byte, exit after the last byte
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_RD_I;
      ST_RD_I:   w_state_next = ST_WAIT_I;
      ST_WAIT_I: w_state_next = ST_RD_J;
      ST_RD_J:   w_state_next = ST_WAIT_J;
      ST_WAIT_J: w_state_next = ST_WR_I;
      ST_WR_I:   w_state_next = ST_WR_J;
      ST_WR_J:   w_state_next = ST_RD_F;
      ST_RD_F:   w_state_next = ST_WAIT_F;
      ST_WAIT_F: w_state_next = ST_WR_OUT;
      ST_WR_OUT: w_state_next = (r_k == K_LAST) ? ST_DONE : ST_RD_I;
      ST_DONE:   if (start) w_state_next = ST_RD_I;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: indices, captured S values and ciphertext byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_si  <= '0;
      r_sj  <= '0;
      r_f   <= '0;
      r_enc <= '0;
    end else begin
      if (w_launch) begin
        r_i <= S_ADDR_WIDTH'(1);
        r_j <= '0;
        r_k <= '0;
      end
      unique case (r_state)
        ST_WAIT_I: begin
          r_si <= s_q;
          r_j  <= r_j + S_ADDR_WIDTH'(s_q);
        end
        ST_WAIT_J: r_sj <= s_q;
        ST_WAIT_F: begin
          r_f   <= s_q;
          r_enc <= rom_q;
        end
        ST_WR_OUT: begin
          r_i <= r_i + S_ADDR_WIDTH'(1);
          r_k <= r_k + K_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode: memory strobes are a pure function of state and registers
  always_comb begin
    done         = 1'b0;
    s_address    = '0;
    s_data       = '0;
    s_wren       = 1'b0;
    rom_address  = '0;
    dmsg_address = '0;
    dmsg_data    = '0;
    dmsg_wren    = 1'b0;
    unique case (r_state)
      ST_RD_I: s_address = r_i;
      ST_RD_J: s_address = r_j;
      // swap; when i==j both writes hit one cell and leave si (== sj) there
      ST_WR_I: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
      end
      ST_WR_J: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
      end
      ST_RD_F: begin
        s_address   = S_ADDR_WIDTH'(r_si + r_sj);
        rom_address = r_k[MSG_ADDR_WIDTH-1:0];
      end
      ST_WR_OUT: begin
        dmsg_address = r_k[MSG_ADDR_WIDTH-1:0];
        dmsg_data    = r_f ^ r_enc;
        dmsg_wren    = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: behavioural memories, software RC4 reference
// feeding a plaintext scoreboard, plus timing/boundary checks.
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [4:0] rom_address;
  logic [7:0] rom_q;
  logic [4:0] dmsg_address;
  logic [7:0] dmsg_data;
  logic       dmsg_wren;

  rc4_prga_decrypt #(
    .MSG_LEN(MSG_LEN), .MSG_ADDR_WIDTH(5), .S_ADDR_WIDTH(8), .DATA_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .dmsg_address(dmsg_address), .dmsg_data(dmsg_data), .dmsg_wren(dmsg_wren)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Memories: registered read, write lands at the edge
  logic [7:0] s_mem    [256];
  logic [7:0] init_s   [256];
  logic [7:0] rom_mem  [MSG_LEN];
  logic [7:0] dmsg_mem [MSG_LEN];
  logic       load_req = 1'b0;

  always @(posedge clock) begin
    if (load_req) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= init_s[a];
    end else if (s_wren) begin
      s_mem[s_address] <= s_data;
    end
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[rom_address];
    if (dmsg_wren) dmsg_mem[dmsg_address] <= dmsg_data;
  end

  // Scoreboard: expected {addr,data} pairs popped on each plaintext write
  logic [12:0] exp_q [$];
  bit          sb_en = 1'b1;

  always @(negedge clock) begin
    logic [12:0] e;
    if (dmsg_wren && sb_en) begin
      check_eq("sb_expected_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("dmsg_addr", 32'(dmsg_address), 32'(e[12:8]));
        check_eq("dmsg_data", 32'(dmsg_data), 32'(e[7:0]));
        $display("write dmsg[%0d] = %0d (exp %0d)", dmsg_address, dmsg_data, e[7:0]);
      end
    end
  end

  // Reference RC4 PRGA over the S contents about to be loaded
  task automatic push_expected();
    logic [7:0] s [256];
    logic [7:0] i, j, t, fi;
    for (int a = 0; a < 256; a++) s[a] = init_s[a];
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      fi = s[i] + s[j];
      exp_q.push_back({5'(k), s[fi] ^ rom_mem[k]});
    end
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
  endtask

  task automatic set_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = k0; key[1] = k1; key[2] = k2;
    set_identity();
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + init_s[a] + key[a % 3];
      t = init_s[a]; init_s[a] = init_s[j]; init_s[j] = t;
    end
  endtask

  task automatic load_s();
    @(negedge clock); load_req = 1'b1;
    @(negedge clock); load_req = 1'b0;
  endtask

  int         s_cnt, d_cnt;
  logic [7:0] snap [4];

  // Launch at edge 0 and observe each following cycle at the falling edge
  task automatic run_msg(input bit hold, output int first_wr, output int done_cyc);
    first_wr = -1; done_cyc = -1; s_cnt = 0; d_cnt = 0;
    @(negedge clock);
    push_expected();
    start = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clock);
      if (s_wren) s_cnt++;
      if (dmsg_wren) begin
        d_cnt++;
        if (first_wr < 0) first_wr = cyc;
        if (dmsg_address == 5'd2) begin
          snap[0] = s_mem[1]; snap[1] = s_mem[2]; snap[2] = s_mem[3]; snap[3] = s_mem[5];
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  logic [7:0] t1_plain [MSG_LEN];
  int first_wr, done_cyc, wcnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int a = 0; a < MSG_LEN; a++) rom_mem[a] = 8'd0;
    set_identity();
    load_s();
    @(negedge clock);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_s_addr", 32'(s_address), 0);
    check_eq("rst_s_wren", 32'(s_wren), 0);
    check_eq("rst_dmsg_wren", 32'(dmsg_wren), 0);
    reset = 1'b0;

    // identity S, zero ciphertext
    run_msg(1'b0, first_wr, done_cyc);
    check_eq("t1_first_wr_cycle", 32'(first_wr), 9);
    check_eq("t1_done_cycle", 32'(done_cyc), 289);
    check_eq("t1_s_wren_count", 32'(s_cnt), 64);
    check_eq("t1_dmsg_wren_count", 32'(d_cnt), 32);
    check_eq("t1_dmsg0", 32'(dmsg_mem[0]), 2);
    check_eq("t1_dmsg1", 32'(dmsg_mem[1]), 5);
    check_eq("t1_dmsg2", 32'(dmsg_mem[2]), 7);
    check_eq("t1_S1", 32'(snap[0]), 1);
    check_eq("t1_S2", 32'(snap[1]), 3);
    check_eq("t1_S3", 32'(snap[2]), 5);
    check_eq("t1_S5", 32'(snap[3]), 2);
    wcnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (done) wcnt++;
    end
    check_eq("t1_done_held", 32'(wcnt), 5);
    for (int a = 0; a < MSG_LEN; a++) t1_plain[a] = dmsg_mem[a];

    // restart from DONE with identity S again and ROM[0]=45
    set_identity();
    load_s();
    rom_mem[0] = 8'd45;
    run_msg(1'b0, first_wr, done_cyc);
    check_eq("t2_first_wr_cycle", 32'(first_wr), 9);
    check_eq("t2_done_cycle", 32'(done_cyc), 289);
    check_eq("t2_dmsg0", 32'(dmsg_mem[0]), 47);
    for (int a = 1; a < MSG_LEN; a++) check_eq("t2_repeat_plain", 32'(dmsg_mem[a]), 32'(t1_plain[a]));

    // key-scheduled S (key 00 00 03) with random ciphertext
    set_ksa(8'h00, 8'h00, 8'h03);
    for (int a = 0; a < MSG_LEN; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    load_s();
    run_msg(1'b0, first_wr, done_cyc);
    check_eq("t3_done_cycle", 32'(done_cyc), 289);
    check_eq("t3_s_wren_count", 32'(s_cnt), 64);
    check_eq("t3_dmsg_wren_count", 32'(d_cnt), 32);

    // start held high all along: no restart while busy
    set_identity();
    load_s();
    run_msg(1'b1, first_wr, done_cyc);
    check_eq("t4_done_cycle", 32'(done_cyc), 289);
    check_eq("t4_dmsg_wren_count", 32'(d_cnt), 32);
    sb_en = 1'b0;
    @(negedge clock);
    check_eq("t4_done_drops", 32'(done), 0);
    start = 1'b0;

    // asynchronous reset partway through the restarted run
    repeat (48) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_done", 32'(done), 0);
    check_eq("t5_s_addr", 32'(s_address), 0);
    check_eq("t5_s_data", 32'(s_data), 0);
    check_eq("t5_s_wren", 32'(s_wren), 0);
    check_eq("t5_rom_addr", 32'(rom_address), 0);
    check_eq("t5_dmsg_addr", 32'(dmsg_address), 0);
    check_eq("t5_dmsg_data", 32'(dmsg_data), 0);
    check_eq("t5_dmsg_wren", 32'(dmsg_wren), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wcnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (s_wren || dmsg_wren || done || (s_address != 8'd0)) wcnt++;
    end
    check_eq("t5_idle_quiet", 32'(wcnt), 0);
    sb_en = 1'b1;

    // fresh run from IDLE after reset
    set_identity();
    for (int a = 0; a < MSG_LEN; a++) rom_mem[a] = 8'd0;
    load_s();
    run_msg(1'b0, first_wr, done_cyc);
    check_eq("t6_first_wr_cycle", 32'(first_wr), 9);
    check_eq("t6_done_cycle", 32'(done_cyc), 289);
    check_eq("t6_sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
